// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arbiter
//  Description : Two-master / one-slave Wishbone arbiter for the shared SDRAM
//                port. Master 0 is the video framebuffer reader and master 1
//                is the framebuffer writer. Grants switch only at transaction
//                boundaries. Bus occupancy is bounded by HOLD_MAX acks.
//                Optional macro WSHB_ARB_VIDEO_PRIO_EN gives master 0
//                absolute priority instead of round-robin/HOLD_MAX fairness.
//  Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int HOLD_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (video reader)
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_adr,
    input  logic [DW/8-1:0]   m0_sel,
    input  logic [DW-1:0]     m0_dat_ms,
    output logic [DW-1:0]     m0_dat_sm,
    output logic              m0_ack,
    // master 1 (framebuffer writer)
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_adr,
    input  logic [DW/8-1:0]   m1_sel,
    input  logic [DW-1:0]     m1_dat_ms,
    output logic [DW-1:0]     m1_dat_sm,
    output logic              m1_ack,
    // slave
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_adr,
    output logic [DW/8-1:0]   s_sel,
    output logic [DW-1:0]     s_dat_ms,
    input  logic [DW-1:0]     s_dat_sm,
    input  logic              s_ack
);

    localparam int              c_CW       = $clog2(HOLD_MAX + 1);
    localparam logic [c_CW-1:0] c_HOLD_MAX = HOLD_MAX[c_CW-1:0];

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0]      r_state;
    logic            r_rr_last;
    logic [c_CW-1:0] r_hold_cnt;

    logic            w_req0;
    logic            w_req1;
    logic            w_own0;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_req_other;
    logic            w_boundary;
    logic            w_yield;
    logic [c_CW-1:0] w_cnt_next;
    logic [1:0]      w_other_state;

    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;
    assign w_own0 = (r_state == c_OWN0);

    // Owner-relative view so that both OWN states share one set of rules
    assign w_own_cyc     = w_own0 ? m0_cyc : m1_cyc;
    assign w_own_stb     = w_own0 ? m0_stb : m1_stb;
    assign w_req_other   = w_own0 ? w_req1 : w_req0;
    assign w_other_state = w_own0 ? c_OWN1 : c_OWN0;

    // A boundary is a completed beat or an idle strobe; never mid-beat
    assign w_boundary = s_ack | ~w_own_stb;

    // Ack count including the current ack, saturating so it never wraps
    assign w_cnt_next = (s_ack && (r_hold_cnt != c_HOLD_MAX)) ? r_hold_cnt + 1'b1 : r_hold_cnt;

`ifdef WSHB_ARB_VIDEO_PRIO_EN
    // Video reader preempts the writer at its next boundary; the writer only
    // gets in when the reader's FIFO throttles its strobe
    assign w_yield = w_own0 ? (~m0_stb & w_req1) : (w_boundary & w_req0);
`else
    logic w_hold_expired;
    assign w_hold_expired = (w_cnt_next >= c_HOLD_MAX);
    // Yield on an idle strobe, or after the hold budget is spent
    assign w_yield = w_req_other & w_boundary & (~w_own_stb | w_hold_expired);
`endif

    // Grant state machine with round-robin memory and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rr_last  <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_req0 && w_req1) begin
`ifdef WSHB_ARB_VIDEO_PRIO_EN
                        r_state   <= c_OWN0;
                        r_rr_last <= 1'b0;
`else
                        r_state   <= r_rr_last ? c_OWN0 : c_OWN1;
                        r_rr_last <= ~r_rr_last;
`endif
                    end else if (w_req0) begin
                        r_state   <= c_OWN0;
                        r_rr_last <= 1'b0;
                    end else if (w_req1) begin
                        r_state   <= c_OWN1;
                        r_rr_last <= 1'b1;
                    end
                end
                c_OWN0, c_OWN1: begin
                    if (!w_own_cyc) begin
                        r_hold_cnt <= '0;
                        if (w_req_other) begin
                            r_state   <= w_other_state;
                            r_rr_last <= w_own0;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else if (w_yield) begin
                        r_hold_cnt <= '0;
                        r_state    <= w_other_state;
                        r_rr_last  <= w_own0;
                    end else begin
                        r_hold_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // Read data is broadcast; only the owner's handshake is routed
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

    // Slave-side mux and ack steering, driven from the registered grant
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_ms = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        case (r_state)
            c_OWN0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_ms = m0_dat_ms;
                m0_ack   = s_ack;
            end
            c_OWN1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_ms = m1_dat_ms;
                m1_ack   = s_ack;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_arbiter
//  Description : Randomized self-checking bench for wshb_arbiter against a
//                behavioural grant model (owner / ack count / last winner).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int HOLD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0]   m0_adr = '0;
    logic [DW/8-1:0] m0_sel = '0;
    logic [DW-1:0]   m0_dat_ms = '0;
    logic [DW-1:0]   m0_dat_sm;
    logic            m0_ack;
    logic            m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0]   m1_adr = '0;
    logic [DW/8-1:0] m1_sel = '0;
    logic [DW-1:0]   m1_dat_ms = '0;
    logic [DW-1:0]   m1_dat_sm;
    logic            m1_ack;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW/8-1:0] s_sel;
    logic [DW-1:0]   s_dat_ms;
    logic [DW-1:0]   s_dat_sm = '0;
    logic            s_ack = 1'b0;

    wshb_arbiter #(.DW(DW), .AW(AW), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: who owns the port (-1 = nobody), who won last, acks taken
    int mdl_own  = -1;
    int mdl_rr   = 1;
    int mdl_acks = 0;

    logic        last_ack0 = 1'b0;
    logic        last_ack1 = 1'b0;
    logic [31:0] a0 = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t own=%0d)", tag, got, exp, $time, mdl_own);
        end
    endtask

    // One bus cycle: drive masters and slave, check outputs, advance the model
    task automatic step(input int p0, input int p1, input int pack, input int prst, input bit drop0);
        logic            e_cyc, e_stb, e_we, e_ack0, e_ack1;
        logic [AW-1:0]   e_adr;
        logic [DW/8-1:0] e_sel;
        logic [DW-1:0]   e_dat;
        bit              cyc[2], stb[2], req[2];
        int              k, o;
        bit              sw, go_idle;

        @(negedge clk);
        // Master 0: video reader, new beat only once the previous one is acked
        if (!(m0_stb && !last_ack0)) begin
            m0_stb = ($urandom_range(99) < p0);
            if (m0_stb) begin
                m0_adr    = a0;
                a0        = a0 + 32'd4;
                m0_we     = 1'b0;
                m0_sel    = '1;
                m0_dat_ms = $urandom;
            end
            m0_cyc = m0_stb ? 1'b1 : !(drop0 && ($urandom_range(99) < 20));
        end
        // Master 1: writer, holds its request until acked
        if (!(m1_stb && !last_ack1)) begin
            m1_stb = ($urandom_range(99) < p1);
            if (m1_stb) begin
                m1_adr    = 32'h1000 + {$urandom_range(255), 2'b00};
                m1_we     = $urandom_range(1);
                m1_sel    = $urandom_range(15);
                m1_dat_ms = $urandom;
            end
            m1_cyc = m1_stb | ($urandom_range(99) < 50);
        end
        rst = ($urandom_range(99) < prst);

        // Expected slave side from the model's owner
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_sel = '0; e_dat = '0;
        if (mdl_own == 0) begin
            e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we;
            e_adr = m0_adr; e_sel = m0_sel; e_dat = m0_dat_ms;
        end else if (mdl_own == 1) begin
            e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we;
            e_adr = m1_adr; e_sel = m1_sel; e_dat = m1_dat_ms;
        end

        // Slave: acks strobes at a given rate; occasionally a stray ack while idle
        s_dat_sm = $urandom;
        s_ack    = e_stb ? ($urandom_range(99) < pack) : (mdl_own < 0 && $urandom_range(99) < 10);
        e_ack0   = (mdl_own == 0) && s_ack;
        e_ack1   = (mdl_own == 1) && s_ack;

        #1;
        check_eq("s_cyc", s_cyc, e_cyc);
        check_eq("s_stb", s_stb, e_stb);
        check_eq("s_we", s_we, e_we);
        check_eq("s_adr", s_adr, e_adr);
        check_eq("s_sel", s_sel, e_sel);
        check_eq("s_dat_ms", s_dat_ms, e_dat);
        check_eq("m0_ack", m0_ack, e_ack0);
        check_eq("m1_ack", m1_ack, e_ack1);
        check_eq("m0_dat_sm", m0_dat_sm, s_dat_sm);
        check_eq("m1_dat_sm", m1_dat_sm, s_dat_sm);
        last_ack0 = e_ack0;
        last_ack1 = e_ack1;

        // Model update for the coming clock edge
        cyc[0] = m0_cyc; stb[0] = m0_stb; req[0] = m0_cyc && m0_stb;
        cyc[1] = m1_cyc; stb[1] = m1_stb; req[1] = m1_cyc && m1_stb;
        if (rst) begin
            mdl_own = -1; mdl_rr = 1; mdl_acks = 0;
        end else if (mdl_own < 0) begin
            k = -1;
            if (req[0] && req[1]) begin
`ifdef WSHB_ARB_VIDEO_PRIO_EN
                k = 0;
`else
                k = 1 - mdl_rr;
`endif
            end else if (req[0]) k = 0;
            else if (req[1]) k = 1;
            if (k >= 0) begin
                mdl_own = k; mdl_rr = k; mdl_acks = 0;
            end
        end else begin
            k = mdl_own;
            o = 1 - k;
            if (s_ack) mdl_acks = (mdl_acks + 1 > HOLD) ? HOLD : mdl_acks + 1;
            sw = 0; go_idle = 0;
            if (!cyc[k]) begin
                if (req[o]) sw = 1; else go_idle = 1;
            end else if (req[o] && (s_ack || !stb[k])) begin
`ifdef WSHB_ARB_VIDEO_PRIO_EN
                sw = (k == 1) || !stb[0];
`else
                sw = !stb[k] || (mdl_acks >= HOLD);
`endif
            end
            if (sw) begin
                mdl_own = o; mdl_rr = o; mdl_acks = 0;
            end else if (go_idle) begin
                mdl_own = -1; mdl_acks = 0;
            end
        end
    endtask

    initial begin
        // Reset held: everything idle, stray acks must not reach masters
        repeat (3) step(0, 0, 100, 100, 1'b0);
        // Video reader alone with a slave that acks every cycle
        repeat (25) step(100, 0, 100, 0, 1'b0);
        // Both masters saturating: fairness switch after HOLD acks each way
        repeat (80) step(100, 100, 100, 0, 1'b0);
        // Wait states, FIFO throttling, cyc drops
        repeat (700) step(70, 60, 40, 0, 1'b1);
        // Same traffic with occasional reset mid-transaction
        repeat (500) step(75, 65, 55, 3, 1'b1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
